// File: rtl/ps2_letter_decoder.sv
// PS/2 set-2 keyboard receiver that reports the letter of each released key (A=1..Z=26, 31=other).
// Define PS2_PARITY_CHECK_EN to drop frames with bad odd parity and pulse parityError.
module ps2_letter_decoder #(
  parameter int unsigned FILTER_LEN     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2Clk,
  input  logic       ps2Data,
  output logic [4:0] keystroke,
  output logic       keyReleased,
  output logic       parityError
);

  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [1:0]    clk_sync;
  logic [1:0]    data_sync;
  logic          filt;
  logic          filt_d;
  logic [FW-1:0] flt_cnt;
  logic          sample_en;
  state_t        state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          brk_pending;
  logic          ext_pending;
  logic [TW-1:0] tout;
  logic          par_err_c;
`ifdef PS2_PARITY_CHECK_EN
  logic          par_bit;
`endif

  function automatic logic [4:0] letter_code(input logic [7:0] sc);
    logic [4:0] code;
    case (sc)
      8'h1C: code = 5'd1;   8'h32: code = 5'd2;   8'h21: code = 5'd3;
      8'h23: code = 5'd4;   8'h24: code = 5'd5;   8'h2B: code = 5'd6;
      8'h34: code = 5'd7;   8'h33: code = 5'd8;   8'h43: code = 5'd9;
      8'h3B: code = 5'd10;  8'h42: code = 5'd11;  8'h4B: code = 5'd12;
      8'h3A: code = 5'd13;  8'h31: code = 5'd14;  8'h44: code = 5'd15;
      8'h4D: code = 5'd16;  8'h15: code = 5'd17;  8'h2D: code = 5'd18;
      8'h1B: code = 5'd19;  8'h2C: code = 5'd20;  8'h3C: code = 5'd21;
      8'h2A: code = 5'd22;  8'h1D: code = 5'd23;  8'h22: code = 5'd24;
      8'h35: code = 5'd25;  8'h1A: code = 5'd26;
      default: code = 5'd31;
    endcase
    return code;
  endfunction

  // Synchronisers, ps2Clk glitch filter and delayed falling-edge strobe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      filt      <= 1'b1;
      filt_d    <= 1'b1;
      flt_cnt   <= '0;
      sample_en <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[0], ps2Clk};
      data_sync <= {data_sync[0], ps2Data};
      filt_d    <= filt;
      sample_en <= filt_d & ~filt;
      if (clk_sync[1] == filt) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
        filt    <= clk_sync[1];
        flt_cnt <= '0;
      end else begin
        flt_cnt <= flt_cnt + FW'(1);
      end
    end
  end

`ifdef PS2_PARITY_CHECK_EN
  assign par_err_c = ~(^{shift, par_bit});
`else
  assign par_err_c = 1'b0;
`endif

  // Frame FSM, byte interpretation and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shift       <= '0;
      brk_pending <= 1'b0;
      ext_pending <= 1'b0;
      tout        <= '0;
      keystroke   <= '0;
      keyReleased <= 1'b0;
      parityError <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      par_bit     <= 1'b0;
`endif
    end else begin
      keyReleased <= 1'b0;
      parityError <= 1'b0;
      if (sample_en) begin
        tout <= '0;
        case (state)
          IDLE: begin
            if (!data_sync[1]) begin
              state   <= DATA;
              bit_cnt <= '0;
              shift   <= '0;
            end
          end
          DATA: begin
            shift   <= {data_sync[1], shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
            par_bit <= data_sync[1];
`endif
            state <= STOP;
          end
          default: begin
            state   <= IDLE;
            bit_cnt <= '0;
            if (!data_sync[1]) begin
              // framing error: silent drop
            end else if (par_err_c) begin
              parityError <= 1'b1;
            end else if (shift == 8'hF0) begin
              brk_pending <= 1'b1;
            end else if (shift == 8'hE0) begin
              ext_pending <= 1'b1;
            end else if (ext_pending) begin
              brk_pending <= 1'b0;
              ext_pending <= 1'b0;
            end else if (brk_pending) begin
              keystroke   <= letter_code(shift);
              keyReleased <= 1'b1;
              brk_pending <= 1'b0;
              ext_pending <= 1'b0;
            end else begin
              ext_pending <= 1'b0;
            end
          end
        endcase
      end else if (state != IDLE) begin
        // Abandon a stalled frame but keep break/extended prefixes
        if (tout == TW'(TIMEOUT_CYCLES - 1)) begin
          state   <= IDLE;
          bit_cnt <= '0;
          shift   <= '0;
          tout    <= '0;
        end else begin
          tout <= tout + TW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_letter_decoder.sv
// Directed bench for ps2_letter_decoder: release decoding, prefixes, parity, timeout, glitch and reset.
module tb_ps2_letter_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2Clk = 1'b1;
  logic       ps2Data = 1'b1;
  logic [4:0] keystroke;
  logic       keyReleased;
  logic       parityError;

  int checks = 0;
  int failures = 0;
  int rel_cnt = 0;
  int perr_cnt = 0;
  int dbl_cnt = 0;
  logic prev_rel = 1'b0;

  ps2_letter_decoder #(.FILTER_LEN(4), .TIMEOUT_CYCLES(200)) dut (
    .clk(clk), .reset(reset), .ps2Clk(ps2Clk), .ps2Data(ps2Data),
    .keystroke(keystroke), .keyReleased(keyReleased), .parityError(parityError)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (keyReleased) rel_cnt++;
    if (parityError) perr_cnt++;
    if (keyReleased && prev_rel) dbl_cnt++;
    prev_rel = keyReleased;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One PS/2 bit: data settles while clock high, then a low half-period
  task automatic send_bit(input logic b, input bit glitch);
    ps2Data = b;
    if (glitch) begin
      repeat (3) @(posedge clk);
      ps2Clk = 1'b0;
      repeat (2) @(posedge clk);
      ps2Clk = 1'b1;
      repeat (7) @(posedge clk);
    end else begin
      repeat (10) @(posedge clk);
    end
    ps2Clk = 1'b0;
    repeat (10) @(posedge clk);
    ps2Clk = 1'b1;
  endtask

  // First nbits of the 11-bit frame; glitch_at < 0 means no glitch
  task automatic send_frame(input logic [7:0] sc, input bit bad_par, input int nbits, input int glitch_at);
    logic [10:0] bits;
    bits = {1'b1, (~^sc) ^ bad_par, sc, 1'b0};
    for (int i = 0; i < nbits; i++) send_bit(bits[i], i == glitch_at);
    ps2Data = 1'b1;
    repeat (30) @(posedge clk);
  endtask

  task automatic send_byte(input logic [7:0] sc);
    send_frame(sc, 1'b0, 11, -1);
  endtask

  int r0, p0;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_keystroke", 32'(keystroke), 32'd0);
    check_val("reset_released", 32'(keyReleased), 32'd0);
    check_val("reset_parity", 32'(parityError), 32'd0);
    reset = 1'b0;
    repeat (5) @(posedge clk);

    r0 = rel_cnt;
    send_byte(8'h1C);
    check_val("make_no_pulse", 32'(rel_cnt - r0), 32'd0);
    check_val("make_keystroke", 32'(keystroke), 32'd0);

    r0 = rel_cnt; p0 = perr_cnt;
    send_byte(8'hF0);
    send_byte(8'h1C);
    check_val("rel_a_keystroke", 32'(keystroke), 32'd1);
    check_val("rel_a_pulses", 32'(rel_cnt - r0), 32'd1);
    check_val("rel_a_parity", 32'(perr_cnt - p0), 32'd0);

    r0 = rel_cnt; p0 = perr_cnt;
    send_byte(8'hF0);
    send_frame(8'h1A, 1'b1, 11, -1);
`ifdef PS2_PARITY_CHECK_EN
    check_val("badpar_perr", 32'(perr_cnt - p0), 32'd1);
    check_val("badpar_no_rel", 32'(rel_cnt - r0), 32'd0);
    check_val("badpar_keystroke", 32'(keystroke), 32'd1);
`else
    check_val("badpar_perr", 32'(perr_cnt - p0), 32'd0);
    check_val("badpar_rel", 32'(rel_cnt - r0), 32'd1);
    check_val("badpar_keystroke", 32'(keystroke), 32'd26);
`endif

    r0 = rel_cnt;
    send_byte(8'hF0);
    send_frame(8'h24, 1'b0, 11, 4);
    check_val("glitch_keystroke", 32'(keystroke), 32'd5);
    check_val("glitch_pulses", 32'(rel_cnt - r0), 32'd1);

    r0 = rel_cnt;
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h75);
    check_val("ext_no_pulse", 32'(rel_cnt - r0), 32'd0);
    send_byte(8'hF0);
    send_byte(8'h5A);
    check_val("other_keystroke", 32'(keystroke), 32'd31);
    check_val("other_pulses", 32'(rel_cnt - r0), 32'd1);

    r0 = rel_cnt;
    send_byte(8'hF0);
    send_frame(8'h1C, 1'b0, 4, -1);
    repeat (300) @(posedge clk);
    send_byte(8'h1C);
    check_val("timeout_keystroke", 32'(keystroke), 32'd1);
    check_val("timeout_pulses", 32'(rel_cnt - r0), 32'd1);

    send_byte(8'hF0);
    send_frame(8'h1C, 1'b0, 5, -1);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check_val("midreset_keystroke", 32'(keystroke), 32'd0);
    check_val("midreset_released", 32'(keyReleased), 32'd0);
    check_val("midreset_parity", 32'(parityError), 32'd0);
    repeat (4) @(posedge clk);
    #1 reset = 1'b0;
    repeat (5) @(posedge clk);
    r0 = rel_cnt;
    send_byte(8'hF0);
    send_byte(8'h2D);
    check_val("after_reset_keystroke", 32'(keystroke), 32'd18);
    check_val("after_reset_pulses", 32'(rel_cnt - r0), 32'd1);

    check_val("no_double_pulse", 32'(dbl_cnt), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_letter_decoder.md
PS2_LETTER_DECODER -- requirements
Module: ps2_letter_decoder

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 4: cycles ps2Clk must be stable before its filtered level changes.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 100000: idle cycles inside a frame before the frame is abandoned.
REQ-003 SHALL have port clk, input, 1: system clock; the block uses one clock.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port ps2Clk, input, 1: raw PS/2 clock line, asynchronous to clk.
REQ-006 SHALL have port ps2Data, input, 1: raw PS/2 data line, asynchronous to clk.
REQ-007 SHALL have port keystroke, output, 5: letter code of the last released key; A=1..Z=26, 31=non-letter, 0=none yet.
REQ-008 SHALL have port keyReleased, output, 1: one-cycle pulse when keystroke is updated.
REQ-009 SHALL have port parityError, output, 1: one-cycle pulse when a frame is dropped for bad parity.

Function
REQ-010 SHALL pass ps2Clk and ps2Data through 2-flop synchronisers, then filter ps2Clk; the filtered level changes only after FILTER_LEN consecutive equal samples.
REQ-011 SHALL sample synchronised ps2Data on each falling edge of filtered ps2Clk, one clk cycle after the edge is detected.
REQ-012 SHALL run FSM IDLE->DATA->PARITY->STOP->IDLE with 8 data bits shifted LSB first and a 3-bit bit counter.
REQ-013 SHALL stay in IDLE when the sampled start bit is 1.
REQ-014 SHALL compute odd parity over the 8 data bits plus the parity bit; on mismatch SHALL pulse parityError in the cycle after the stop-bit sample and discard the byte.
REQ-015 SHALL discard the byte without any pulse when the stop bit samples 0.
REQ-016 SHALL return to IDLE and clear the bit counter and partial byte when TIMEOUT_CYCLES clk cycles pass in a non-IDLE state with no falling edge; pending flags are kept.
REQ-017 SHALL handle byte 8'hF0 by setting breakPending, with no output.
REQ-018 SHALL handle byte 8'hE0 by setting extPending, with no output.
REQ-019 SHALL, for any other byte with breakPending=1 and extPending=0, load keystroke and pulse keyReleased in the cycle after the stop-bit sample, then clear both flags.
REQ-020 SHALL map set-2 scancodes 1C,32,21,23,24,2B,34,33,43,3B,42,4B,3A,31,44,4D,15,2D,1B,2C,3C,2A,1D,22,35,1A to A..Z = 1..26; every other code SHALL map to 31.
REQ-021 SHALL ignore a byte with extPending=1 apart from clearing flags: a non-F0 byte clears both flags, and F0 keeps extPending set.
REQ-022 SHALL produce no output for a make code (breakPending=0) and clear extPending.
REQ-023 SHALL hold keystroke between updates; keyReleased SHALL never be high for two consecutive cycles.
REQ-024 SHALL complete the current frame normally if a filter glitch shorter than FILTER_LEN occurs mid-frame, with no extra bit sampled.

Reset
REQ-025 SHALL, on reset assertion and independent of clk, set keystroke=0, keyReleased=0, parityError=0, FSM=IDLE, bit counter=0, shift register=0, both pending flags=0, timeout counter=0, synchronisers and filter output=1.
REQ-026 SHALL discard a frame interrupted by reset; after release, decoding SHALL restart at the next start bit.

Configuration
REQ-027 SHALL provide macro PS2_PARITY_CHECK_EN; when defined, REQ-014 applies.
REQ-028 SHALL, without PS2_PARITY_CHECK_EN, accept the parity bit unchecked, tie parityError to 0, and leave all other behaviour unchanged.

Verification
REQ-029 SHALL be verified with frames F0 then 1C, valid parity -> keystroke=1, one keyReleased pulse, parityError=0.
REQ-030 SHALL be verified with make 1C only -> no keyReleased, keystroke stays 0.
REQ-031 SHALL be verified with F0 then 1A sent with wrong parity, macro defined -> parityError pulse, no keyReleased; macro undefined -> keystroke=26 pulse.
REQ-032 SHALL be verified with E0,F0,75 then F0,5A -> no pulse for 75; pulse with keystroke=31 for 5A.
REQ-033 SHALL be verified with F0 then 4 bits of 1C, stall > TIMEOUT_CYCLES, then a full 1C -> single pulse, keystroke=1.
REQ-034 SHALL be verified with reset asserted mid-frame of 1C after F0 -> outputs 0 at once; subsequent F0,2D -> keystroke=18.
